// File: rtl/jtag_tap_ctrl_if.sv
// jtag_tap_ctrl_if: signal bundle between the TAP controller and its
// surroundings (test driver, scan cells, instruction register).
//   slave  : the TAP controller side. It consumes TMS and the two serial
//            returns, and produces state, the strobes, TDO and tdo_en.
//   master : the driver/environment side, with the directions mirrored.
interface jtag_tap_ctrl_if;
  logic       TMS;
  logic       dr_tdo;
  logic       ir_tdo;
  logic [3:0] state;
  logic       clockdr;
  logic       shiftdr;
  logic       updatedr;
  logic       clockir;
  logic       shiftir;
  logic       updateir;
  logic       tlr;
  logic       TDO;
  logic       tdo_en;

  modport master (
    output TMS, dr_tdo, ir_tdo,
    input  state, clockdr, shiftdr, updatedr, clockir, shiftir, updateir,
           tlr, TDO, tdo_en
  );

  modport slave (
    input  TMS, dr_tdo, ir_tdo,
    output state, clockdr, shiftdr, updatedr, clockir, shiftir, updateir,
           tlr, TDO, tdo_en
  );
endinterface

// File: rtl/jtag_tap_ctrl.sv
// jtag_tap_ctrl: IEEE 1149.1-style 16-state TAP controller.
// Ports:
//   TCK  : clock, all state updates on the rising edge
//   TRST : synchronous active-high reset, forces Test-Logic-Reset
//   bus  : jtag_tap_ctrl_if.slave
//          in : TMS, dr_tdo, ir_tdo
//          out: state (4b), clockdr, shiftdr, updatedr, clockir, shiftir,
//               updateir, tlr (Moore decodes of state), TDO, tdo_en (registered)
module jtag_tap_ctrl (
  input  logic              TCK,
  input  logic              TRST,
  jtag_tap_ctrl_if.slave    bus
);

  typedef enum logic [3:0] {
    TLR     = 4'hF,
    RTI     = 4'hC,
    SEL_DR  = 4'h7,
    CAP_DR  = 4'h6,
    SH_DR   = 4'h2,
    EX1_DR  = 4'h1,
    PAU_DR  = 4'h3,
    EX2_DR  = 4'h0,
    UPD_DR  = 4'h5,
    SEL_IR  = 4'h4,
    CAP_IR  = 4'hE,
    SH_IR   = 4'hA,
    EX1_IR  = 4'h9,
    PAU_IR  = 4'hB,
    EX2_IR  = 4'h8,
    UPD_IR  = 4'hD
  } state_e;

  state_e state_q, state_d;
  logic   tdo_q, tdo_d;
  logic   tdo_en_q, tdo_en_d;

  always_ff @(posedge TCK) begin
    if (TRST) begin
      state_q  <= TLR;
      tdo_q    <= 1'b0;
      tdo_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      tdo_q    <= tdo_d;
      tdo_en_q <= tdo_en_d;
    end
  end

  always_comb begin
    state_d = TLR;
    case (state_q)
      TLR:     state_d = bus.TMS ? TLR    : RTI;
      RTI:     state_d = bus.TMS ? SEL_DR : RTI;
      SEL_DR:  state_d = bus.TMS ? SEL_IR : CAP_DR;
      CAP_DR:  state_d = bus.TMS ? EX1_DR : SH_DR;
      SH_DR:   state_d = bus.TMS ? EX1_DR : SH_DR;
      EX1_DR:  state_d = bus.TMS ? UPD_DR : PAU_DR;
      PAU_DR:  state_d = bus.TMS ? EX2_DR : PAU_DR;
      EX2_DR:  state_d = bus.TMS ? UPD_DR : SH_DR;
      UPD_DR:  state_d = bus.TMS ? SEL_DR : RTI;
      SEL_IR:  state_d = bus.TMS ? TLR    : CAP_IR;
      CAP_IR:  state_d = bus.TMS ? EX1_IR : SH_IR;
      SH_IR:   state_d = bus.TMS ? EX1_IR : SH_IR;
      EX1_IR:  state_d = bus.TMS ? UPD_IR : PAU_IR;
      PAU_IR:  state_d = bus.TMS ? EX2_IR : PAU_IR;
      EX2_IR:  state_d = bus.TMS ? UPD_IR : SH_IR;
      UPD_IR:  state_d = bus.TMS ? SEL_DR : RTI;
      // All 16 codes are named; this only catches X/corruption.
      default: state_d = TLR;
    endcase
  end

  // TDO captures the serial return of whichever chain is shifting in the
  // current cycle and otherwise holds, so Pause states freeze it.
  always_comb begin
    tdo_d    = tdo_q;
    tdo_en_d = 1'b0;
    if (state_q == SH_DR) begin
      tdo_d    = bus.dr_tdo;
      tdo_en_d = 1'b1;
    end else if (state_q == SH_IR) begin
      tdo_d    = bus.ir_tdo;
      tdo_en_d = 1'b1;
    end
  end

  // Strobes depend on state_q alone, so they cannot glitch with TMS.
  assign bus.state    = state_q;
  assign bus.clockdr  = (state_q == CAP_DR) || (state_q == SH_DR);
  assign bus.shiftdr  = (state_q == SH_DR);
  assign bus.updatedr = (state_q == UPD_DR);
  assign bus.clockir  = (state_q == CAP_IR) || (state_q == SH_IR);
  assign bus.shiftir  = (state_q == SH_IR);
  assign bus.updateir = (state_q == UPD_IR);
  assign bus.tlr      = (state_q == TLR);
  assign bus.TDO      = tdo_q;
  assign bus.tdo_en   = tdo_en_q;

endmodule

// File: doc/jtag_tap_ctrl.md
# jtag_tap_ctrl

IEEE 1149.1-style TAP controller: the 16-state FSM that steps on TMS and generates the capture/shift/update strobes for the boundary-scan data chain and the 2-bit instruction register. It sits directly upstream of the scan cells and the instruction register. It also muxes their serial outputs onto the chip-level TDO.

## Interface
Parameters:
- none; the state encoding is fixed as listed under Operation.

Ports:
- `TCK` in 1: the single clock. Everything updates on the rising edge.
- `TRST` in 1: reset, synchronous, active-high. Forces Test-Logic-Reset.
- `TMS` in 1: test mode select, sampled each rising `TCK`.
- `dr_tdo` in 1: serial output of the last boundary-scan cell.
- `ir_tdo` in 1: serial output of the instruction register.
- `state` out 4: current FSM state code.
- `clockdr` out 1: data-register capture/shift enable. High in Capture-DR or Shift-DR.
- `shiftdr` out 1: high in Shift-DR only.
- `updatedr` out 1: high in Update-DR only.
- `clockir` out 1: high in Capture-IR or Shift-IR.
- `shiftir` out 1: high in Shift-IR only.
- `updateir` out 1: high in Update-IR only.
- `tlr` out 1: high in Test-Logic-Reset. Downstream logic uses it to clear the instruction register.
- `TDO` out 1: registered serial output.
- `tdo_en` out 1: TDO drive enable (registered).

## Operation
- State register is 4 bits. Encoding:
  - TLR=F, RTI=C, SelDR=7, CapDR=6, ShDR=2, Ex1DR=1, PauseDR=3, Ex2DR=0, UpdDR=5
  - SelIR=4, CapIR=E, ShIR=A, Ex1IR=9, PauseIR=B, Ex2IR=8, UpdIR=D
- Transitions, written as next state for TMS=0 / TMS=1:
  - TLR: RTI / TLR
  - RTI: RTI / SelDR
  - SelDR: CapDR / SelIR
  - CapDR: ShDR / Ex1DR
  - ShDR: ShDR / Ex1DR
  - Ex1DR: PauseDR / UpdDR
  - PauseDR: PauseDR / Ex2DR
  - Ex2DR: ShDR / UpdDR
  - UpdDR: RTI / SelDR
  - SelIR: CapIR / TLR
  - CapIR, ShIR, Ex1IR, PauseIR, Ex2IR, UpdIR: mirror the DR column.
- Any illegal code is unreachable in practice. If it does occur, it transitions to TLR.
- Strobe outputs are pure Moore decodes of `state`. No glitch-prone terms from `TMS`.
- `clockdr` and `clockir` are never both high. `shiftdr` and `shiftir` are never both high.
- TDO path, each rising edge:
  - If the current state is ShDR: `TDO` <= `dr_tdo`.
  - Else if ShIR: `TDO` <= `ir_tdo`.
  - Otherwise `TDO` holds its value.
  - `tdo_en` <= (state==ShDR) or (state==ShIR).
- Five consecutive TMS=1 samples reach TLR from any state. This must hold with `TRST` never asserted.

## Timing
- Reset: `TRST` high at a rising edge drives:
  - `state`=F, `tlr`=1
  - all six strobes 0
  - `TDO`=0, `tdo_en`=0
- `TRST` has priority over `TMS`. Asserting it mid-shift aborts the scan in one cycle. No update strobe is issued.
- Latency:
  - State changes one cycle after the `TMS` sample.
  - Strobes are valid in the same cycle as the state (combinational decode of the state register).
  - `TDO` and `tdo_en` lag the Shift state by one cycle.
  - The first shifted bit appears on `TDO` the cycle after entry to ShDR/ShIR.
- Update strobes are exactly one cycle wide per pass through UpdDR/UpdIR.
- Back-to-back scans are legal: UpdDR→SelDR with TMS=1 skips RTI.
- Pause states hold all strobes low and freeze `TDO`.

## Test plan
- **Reset:** `TRST`=1 for 1 cycle from ShDR.
  - Required: `state`=F, `tlr`=1, all strobes 0, `TDO`=0, `tdo_en`=0 on the next cycle.
- **Reach ShDR:** from TLR, TMS sequence 0,1,0,0.
  - Required: states C,7,6,2.
  - `clockdr`=1 in states 6 and 2; `shiftdr`=1 only in 2.
  - `tdo_en` rises the cycle after entering 2.
- **DR scan out:** in ShDR, drive `dr_tdo` = 1,0,1,1 with TMS=0,0,0,1.
  - Required: `TDO` shows 1,0,1,1, each one cycle later.
  - Exit to 1, then TMS=1 gives 5 with `updatedr` high for one cycle.
- **IR scan:** from RTI, TMS 1,1,0,0,0,1,1 with `ir_tdo`=0,1.
  - Required: states 7,4,E,A,A,9,D.
  - `shiftir` high for 2 cycles; `updateir` high for 1 cycle.
  - `TDO` shows 0,1.
- **Escape to TLR:** from PauseIR (B), hold TMS=1 for 5 cycles with no `TRST`.
  - Required: states 8,D,7,4,F; `tlr`=1.
- **Pause/resume:** ShDR→Ex1DR→PauseDR with 3 idle cycles→Ex2DR→ShDR.
  - Required: no strobes and `TDO` frozen during Pause.
  - Shifting resumes with correct `TDO` order.
